// File: rtl/smc_mac_lite2.sv
`default_nettype none
// ============================================================================
// Module   : smc_mac_lite2
// Brief    : Multiple-access controller and external-bus sequencer. Splits an
//            AHB transfer into MEM_WIDTH beats, times each beat with wait
//            states and drives the external strobes. Optional read-to-write
//            turnaround cycle is enabled by defining SMC_TURNAROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module smc_mac_lite2 #(
  parameter int MEM_WIDTH = 8,
  parameter int WS_WIDTH  = 4
) (
  input  logic                     hclk2,
  input  logic                     sys_reset2,
  input  logic                     new_access2,
  input  logic                     cs,
  input  logic [31:0]              addr,
  input  logic [1:0]               xfer_size2,
  input  logic                     n_read2,
  input  logic [31:0]              write_data2,
  input  logic [WS_WIDTH-1:0]      ws_rd2,
  input  logic [WS_WIDTH-1:0]      ws_wr2,
  input  logic [MEM_WIDTH-1:0]     smc_data_in2,
  output logic [31:0]              smc_addr2,
  output logic [MEM_WIDTH-1:0]     smc_data_out2,
  output logic                     smc_n_cs2,
  output logic                     smc_n_oe2,
  output logic                     smc_n_we2,
  output logic [MEM_WIDTH/8-1:0]   smc_n_be2,
  output logic [31:0]              read_data2,
  output logic                     smc_done2,
  output logic                     mac_done2,
  output logic                     smc_idle2
);

  localparam int         MB         = MEM_WIDTH / 8;
  localparam int         LANE_SH    = $clog2(MB);
  localparam logic [1:0] LANE_ALIGN = 2'(~(MB - 1));

`ifdef SMC_TURNAROUND_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_TURN   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [31:0]           cap_addr_q, cap_addr_d;
  logic                  wr_q, wr_d;
  logic [WS_WIDTH-1:0]   ws_q, ws_d;
  logic [WS_WIDTH-1:0]   ws_cnt_q, ws_cnt_d;
  logic [1:0]            beat_q, beat_d;
  logic [1:0]            last_q, last_d;
  logic [3:0]            xmask_q, xmask_d;
  logic [31:0]           rd_q, rd_d;

  logic [31:0]           smc_addr_q;
  logic [MEM_WIDTH-1:0]  dout_q;
  logic                  n_cs_q, n_oe_q, n_we_q;
  logic [MB-1:0]         n_be_q;
  logic                  done_q, mac_q, idle_q;

  logic                  w_final_hold;
  logic                  w_capture;
  logic [1:0]            w_size;
  logic [1:0]            w_beats_log;
  logic [3:0]            w_xmask_raw;
  logic [3:0]            w_xmask;
  logic [1:0]            w_lane_q;
  logic [1:0]            w_lane_d;
  logic [4:0]            w_rd_shift;
  logic [31:0]           w_rd_mask;
  logic [31:0]           w_rd_ins;
  logic [31:0]           w_wr_shifted;
  logic [3:0]            w_xm_shift;
  logic                  w_active_d;

  // Byte lane of a beat, aligned down to the external bus width.
  function automatic logic [1:0] lane_of(input logic [31:0] a, input logic [1:0] beat);
    logic [1:0] l;
    l = a[1:0] + (beat << LANE_SH);
    return l & LANE_ALIGN;
  endfunction

  assign w_final_hold = (state_q == S_HOLD) && (beat_q == last_q);
  assign w_capture    = new_access2 && cs && ((state_q == S_IDLE) || w_final_hold);
  assign w_size       = (xfer_size2 == 2'd3) ? 2'd2 : xfer_size2;
  assign w_beats_log  = (w_size > 2'(LANE_SH)) ? (w_size - 2'(LANE_SH)) : 2'd0;

  always_comb begin
    w_xmask_raw = 4'b1111;
    case (w_size)
      2'd0:    w_xmask_raw = 4'b0001;
      2'd1:    w_xmask_raw = 4'b0011;
      default: w_xmask_raw = 4'b1111;
    endcase
  end

  assign w_xmask      = w_xmask_raw << addr[1:0];
  assign w_lane_q     = lane_of(cap_addr_q, beat_q);
  assign w_rd_shift   = {w_lane_q, 3'b000};
  assign w_rd_mask    = 32'({MEM_WIDTH{1'b1}}) << w_rd_shift;
  assign w_rd_ins     = 32'(smc_data_in2) << w_rd_shift;

  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    wr_d       = wr_q;
    ws_d       = ws_q;
    ws_cnt_d   = ws_cnt_q;
    beat_d     = beat_q;
    last_d     = last_q;
    xmask_d    = xmask_q;
    rd_d       = rd_q;

    if (w_capture) begin
      cap_addr_d = addr;
      wr_d       = n_read2;
      ws_d       = n_read2 ? ws_wr2 : ws_rd2;
      beat_d     = 2'd0;
      last_d     = 2'((3'd1 << w_beats_log) - 3'd1);
      xmask_d    = w_xmask;
      rd_d       = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_capture) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d  = S_STROBE;
        ws_cnt_d = ws_q;
      end
      S_STROBE: begin
        if (ws_cnt_q == '0) begin
          state_d = S_HOLD;
          if (!wr_q) rd_d = (rd_q & ~w_rd_mask) | w_rd_ins;
        end else begin
          ws_cnt_d = ws_cnt_q - WS_WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (beat_q != last_q) begin
          state_d = S_SETUP;
          beat_d  = beat_q + 2'd1;
        end else if (w_capture) begin
`ifdef SMC_TURNAROUND_EN
          // Only a read followed by a write needs a bus turnaround cycle.
          state_d = (!wr_q && n_read2) ? S_TURN : S_SETUP;
`else
          state_d = S_SETUP;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef SMC_TURNAROUND_EN
      S_TURN: begin
        state_d = S_SETUP;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign w_lane_d     = lane_of(cap_addr_d, beat_d);
  assign w_wr_shifted = write_data2 >> {w_lane_d, 3'b000};
  assign w_xm_shift   = xmask_d >> w_lane_d;
  assign w_active_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

  // Outputs are decoded from the next state and registered with it.
  always_ff @(posedge hclk2) begin
    if (sys_reset2) begin
      state_q    <= S_IDLE;
      cap_addr_q <= '0;
      wr_q       <= 1'b0;
      ws_q       <= '0;
      ws_cnt_q   <= '0;
      beat_q     <= '0;
      last_q     <= '0;
      xmask_q    <= '0;
      rd_q       <= '0;
      smc_addr_q <= '0;
      dout_q     <= '0;
      n_cs_q     <= 1'b1;
      n_oe_q     <= 1'b1;
      n_we_q     <= 1'b1;
      n_be_q     <= '1;
      done_q     <= 1'b0;
      mac_q      <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
      wr_q       <= wr_d;
      ws_q       <= ws_d;
      ws_cnt_q   <= ws_cnt_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      xmask_q    <= xmask_d;
      rd_q       <= rd_d;
      n_cs_q     <= !w_active_d;
      n_oe_q     <= !((state_d == S_STROBE) && !wr_d);
      n_we_q     <= !((state_d == S_STROBE) && wr_d);
      n_be_q     <= w_active_d ? ~w_xm_shift[MB-1:0] : '1;
      done_q     <= (state_d == S_HOLD);
      mac_q      <= (state_d == S_HOLD) && (beat_d == last_d);
      idle_q     <= (state_d == S_IDLE);
      if (state_d == S_SETUP) smc_addr_q <= cap_addr_d + (32'(beat_d) << LANE_SH);
      if (w_active_d && wr_d) dout_q <= w_wr_shifted[MEM_WIDTH-1:0];
    end
  end

  assign smc_addr2     = smc_addr_q;
  assign smc_data_out2 = dout_q;
  assign smc_n_cs2     = n_cs_q;
  assign smc_n_oe2     = n_oe_q;
  assign smc_n_we2     = n_we_q;
  assign smc_n_be2     = n_be_q;
  assign read_data2    = rd_q;
  assign smc_done2     = done_q;
  assign mac_done2     = mac_q;
  assign smc_idle2     = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_smc_mac_lite2.sv
`default_nettype none
// ============================================================================
// Module   : tb_smc_mac_lite2
// Brief    : Random and directed transfers on an 8-bit and a 32-bit instance
//            of smc_mac_lite2, checked cycle by cycle against a transfer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smc_mac_lite2;

  localparam int NCYC = 4000;
`ifdef SMC_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [1:0]  sz;
    logic        wr;
    logic [3:0]  ws;
    logic [31:0] wd;
  } xfer_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        new_access = 1'b0, cs = 1'b0, n_read = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = '0;
  logic [3:0]  ws_rd = '0, ws_wr = '0;
  logic [7:0]  din8 = '0;
  logic [31:0] din32 = '0;

  logic [31:0] addr8, rd8, addr32, rd32;
  logic [7:0]  dout8;
  logic [31:0] dout32;
  logic [0:0]  be8;
  logic [3:0]  be32;
  logic        ncs8, noe8, nwe8, done8, mac8, idle8;
  logic        ncs32, noe32, nwe32, done32, mac32, idle32;

  smc_mac_lite2 #(.MEM_WIDTH(8), .WS_WIDTH(4)) u_dut8 (
    .hclk2(clk), .sys_reset2(rst), .new_access2(new_access), .cs(cs), .addr(addr),
    .xfer_size2(size), .n_read2(n_read), .write_data2(wdata), .ws_rd2(ws_rd), .ws_wr2(ws_wr),
    .smc_data_in2(din8), .smc_addr2(addr8), .smc_data_out2(dout8), .smc_n_cs2(ncs8),
    .smc_n_oe2(noe8), .smc_n_we2(nwe8), .smc_n_be2(be8), .read_data2(rd8),
    .smc_done2(done8), .mac_done2(mac8), .smc_idle2(idle8)
  );

  smc_mac_lite2 #(.MEM_WIDTH(32), .WS_WIDTH(4)) u_dut32 (
    .hclk2(clk), .sys_reset2(rst), .new_access2(new_access), .cs(cs), .addr(addr),
    .xfer_size2(size), .n_read2(n_read), .write_data2(wdata), .ws_rd2(ws_rd), .ws_wr2(ws_wr),
    .smc_data_in2(din32), .smc_addr2(addr32), .smc_data_out2(dout32), .smc_n_cs2(ncs32),
    .smc_n_oe2(noe32), .smc_n_we2(nwe32), .smc_n_be2(be32), .read_data2(rd32),
    .smc_done2(done32), .mac_done2(mac32), .smc_idle2(idle32)
  );

  // Transfer model: one entry per instance (0 = 8-bit bus, 1 = 32-bit bus).
  bit          act[2], turn[2], mwr[2];
  int          t[2], mbytes[2], mws[2];
  logic [31:0] ma[2], mrd[2], last_addr[2], din_cur[2];
  bit          post_rst;
  int          cur_cyc;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int mbof(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input int d);
    return (d == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic int beats_of(input int d);
    int b;
    b = mbytes[d] / mbof(d);
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int total_of(input int d);
    return beats_of(d) * (3 + mws[d]);
  endfunction

  function automatic int phase_of(input int d);
    return (t[d] - 1) % (3 + mws[d]);
  endfunction

  function automatic bit capturable(input int d);
    return !act[d] || (!turn[d] && t[d] == total_of(d));
  endfunction

  function automatic int lane_of(input int d, input int k);
    int l;
    l = (int'(ma[d][1:0]) + k * mbof(d)) % 4;
    return l - (l % mbof(d));
  endfunction

  task automatic check_dut(input int d);
    logic [31:0] o_addr, o_dout, o_rd, e_addr;
    logic [3:0]  o_be, e_be;
    logic [5:0]  o_ctl, e_ctl;
    int          per, k, p, lane, a1;
    bit          strobe, hold;
    string       pfx;
    pfx = $sformatf("w%0d@%0d", 8 * mbof(d), cur_cyc);
    if (d == 0) begin
      o_addr = addr8; o_dout = 32'(dout8); o_rd = rd8; o_be = {3'b111, be8};
      o_ctl  = {idle8, ncs8, noe8, nwe8, done8, mac8};
    end else begin
      o_addr = addr32; o_dout = dout32; o_rd = rd32; o_be = be32;
      o_ctl  = {idle32, ncs32, noe32, nwe32, done32, mac32};
    end
    if (!act[d]) begin
      chk_eq({pfx, ".idle_ctl"}, 32'(o_ctl), 32'(6'b111100));
      chk_eq({pfx, ".idle_be"}, 32'(o_be), 32'hF);
      chk_eq({pfx, ".idle_addr"}, o_addr, last_addr[d]);
      chk_eq({pfx, ".rdata"}, o_rd, mrd[d]);
      if (post_rst) chk_eq({pfx, ".rst_dout"}, o_dout, 32'h0);
    end else if (turn[d]) begin
      chk_eq({pfx, ".turn_ctl"}, 32'(o_ctl), 32'(6'b011100));
    end else begin
      per    = 3 + mws[d];
      k      = (t[d] - 1) / per;
      p      = phase_of(d);
      strobe = (p >= 1) && (p <= 1 + mws[d]);
      hold   = (p == per - 1);
      e_ctl  = {1'b0, 1'b0, !(strobe && !mwr[d]), !(strobe && mwr[d]), hold,
                hold && (k == beats_of(d) - 1)};
      chk_eq({pfx, ".ctl"}, 32'(o_ctl), 32'(e_ctl));
      e_addr = ma[d] + 32'(k * mbof(d));
      chk_eq({pfx, ".addr"}, o_addr, e_addr);
      last_addr[d] = e_addr;
      lane = lane_of(d, k);
      a1   = int'(ma[d][1:0]);
      e_be = 4'hF;
      for (int j = 0; j < mbof(d); j++)
        if ((lane + j) >= a1 && (lane + j) < a1 + mbytes[d]) e_be[j] = 1'b0;
      chk_eq({pfx, ".be"}, 32'(o_be), 32'(e_be));
      if (strobe && mwr[d])
        chk_eq({pfx, ".dout"}, o_dout, (wdata >> (8 * lane)) & lane_mask(d));
      chk_eq({pfx, ".rdata"}, o_rd, mrd[d]);
    end
  endtask

  task automatic advance(input int d, input bit cap_req, input bit rst_now);
    int          lane;
    logic [31:0] m;
    if (rst_now) begin
      act[d] = 1'b0; turn[d] = 1'b0; mrd[d] = '0; last_addr[d] = '0;
      return;
    end
    if (act[d] && !turn[d] && !mwr[d] && phase_of(d) == 1 + mws[d]) begin
      lane   = lane_of(d, (t[d] - 1) / (3 + mws[d]));
      m      = lane_mask(d) << (8 * lane);
      mrd[d] = (mrd[d] & ~m) | ((din_cur[d] & lane_mask(d)) << (8 * lane));
    end
    if (cap_req && capturable(d)) begin
      turn[d]   = TURN_EN && act[d] && !mwr[d] && n_read;
      act[d]    = 1'b1;
      t[d]      = 1;
      ma[d]     = addr;
      mbytes[d] = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      mwr[d]    = n_read;
      mws[d]    = n_read ? int'(ws_wr) : int'(ws_rd);
      mrd[d]    = '0;
    end else if (act[d]) begin
      if (turn[d]) turn[d] = 1'b0;
      else if (t[d] == total_of(d)) act[d] = 1'b0;
      else t[d]++;
    end
  endtask

  initial begin
    xfer_t q[$];
    xfer_t x;
    bit    rst_done;
    int    bytes;
    q.push_back('{32'h0000_0100, 2'd2, 1'b0, 4'd0,  32'h0});
    q.push_back('{32'h0000_0202, 2'd1, 1'b1, 4'd2,  32'hABCD_1234});
    q.push_back('{32'h0000_0003, 2'd0, 1'b0, 4'd15, 32'h0});
    q.push_back('{32'h0000_0040, 2'd0, 1'b0, 4'd1,  32'h0});
    q.push_back('{32'h0000_0041, 2'd0, 1'b1, 4'd0,  32'h5566_7788});
    q.push_back('{32'h0000_0080, 2'd3, 1'b1, 4'd1,  32'hDEAD_BEEF});
    rst_done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; turn[d] = 1'b0; t[d] = 0; mbytes[d] = 1; mws[d] = 0;
      mwr[d] = 1'b0; ma[d] = '0; mrd[d] = '0; last_addr[d] = '0; din_cur[d] = '0;
    end
    post_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCYC; c++) begin
      bit rst_now, both, neither;
      cur_cyc = c;
      check_dut(0);
      check_dut(1);
      rst_now = !rst_done && c > 400 && act[0] && !turn[0] && !mwr[0] &&
                phase_of(0) >= 1 && phase_of(0) <= 1 + mws[0];
      both       = capturable(0) && capturable(1);
      neither    = !capturable(0) && !capturable(1);
      new_access = 1'b0;
      cs         = 1'b1;
      if (rst_now) begin
        rst_done = 1'b1;
      end else if (both && q.size() > 0) begin
        x = q.pop_front();
        new_access = 1'b1; addr = x.a; size = x.sz; n_read = x.wr;
        ws_rd = x.ws; ws_wr = x.ws; wdata = x.wd;
      end else if (both && $urandom_range(0, 3) != 0) begin
        new_access = 1'b1;
        cs         = ($urandom_range(0, 9) != 0);
        size       = 2'($urandom_range(0, 3));
        bytes      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        addr       = $urandom & ~32'(bytes - 1);
        n_read     = 1'($urandom_range(0, 1));
        ws_rd      = 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
        ws_wr      = 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
        wdata      = $urandom;
      end else if (neither && $urandom_range(0, 7) == 0) begin
        new_access = 1'b1;
        addr       = $urandom & 32'hFFFF_FFFC;
        size       = 2'($urandom_range(0, 3));
        n_read     = 1'($urandom_range(0, 1));
        ws_rd      = 4'($urandom_range(0, 15));
        ws_wr      = 4'($urandom_range(0, 15));
      end
      rst        = rst_now;
      din_cur[0] = $urandom & 32'hFF;
      din_cur[1] = $urandom;
      din8       = din_cur[0][7:0];
      din32      = din_cur[1];
      advance(0, new_access && cs, rst_now);
      advance(1, new_access && cs, rst_now);
      post_rst = rst_now;
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
